// File: rtl/msi001_spi_sequencer_pkg.sv
// Shared types and constants for the MSI001 SPI register-write sequencer.
// Optional SPI_LSB_FIRST_EN (used by msi001_spi_word_tx) flips the per-frame bit order.
package msi001_spi_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_TAIL  = 3'd2,
        ST_GAP   = 3'd3,
        ST_FIN   = 3'd4
    } seq_state_t;

    // Default MSI001 register frames used at tuner bring-up.
    localparam logic [23:0] MSI001_FRAME_A = 24'hEBAEAB;
    localparam logic [23:0] MSI001_FRAME_B = 24'h09AFAB;

    // Number of words actually sent: requests beyond the table size send the whole table.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/msi001_spi_word_tx.sv
// Single-frame SPI serialiser: load accepted when idle, frame starts on the next cycle.
// Latency: en low for (2*DATA_W+1)*CLK_DIV cycles; no backpressure, load ignored while busy.
// SPI_LSB_FIRST_EN defined: bit 0 goes out first; otherwise MSB first.
module msi001_spi_word_tx
    import msi001_spi_sequencer_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [DATA_W-1:0] word,
    output logic              busy,
    output logic              tail,
    output logic              last,
    output logic              sdo,
    output logic              sclk,
    output logic              sen
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] sh_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [DW-1:0]     div;
    logic              first_bit;
    logic              next_bit;
    logic              half_end;

`ifdef SPI_LSB_FIRST_EN
    assign sh_nxt    = sh >> 1;
    assign first_bit = word[0];
    assign next_bit  = sh_nxt[0];
`else
    assign sh_nxt    = sh << 1;
    assign first_bit = word[DATA_W-1];
    assign next_bit  = sh_nxt[DATA_W-1];
`endif

    assign half_end = (div == DIV_LAST);
    // Final tail cycle: lets the sequencer schedule the gap without losing a cycle.
    assign last     = busy && tail && half_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            tail    <= 1'b0;
            sdo     <= 1'b0;
            sclk    <= 1'b0;
            sen     <= 1'b1;
            sh      <= '0;
            bit_cnt <= '0;
            div     <= '0;
        end else if (!busy) begin
            if (load) begin
                busy    <= 1'b1;
                tail    <= 1'b0;
                sen     <= 1'b0;
                sclk    <= 1'b0;
                sh      <= word;
                sdo     <= first_bit;
                bit_cnt <= '0;
                div     <= '0;
            end else if (clr) begin
                sdo <= 1'b0;
            end
        end else begin
            div <= half_end ? '0 : div + DW'(1);
            if (half_end) begin
                if (tail) begin
                    tail <= 1'b0;
                    busy <= 1'b0;
                    sen  <= 1'b1;
                end else if (!sclk) begin
                    sclk <= 1'b1;
                end else begin
                    sclk <= 1'b0;
                    if (bit_cnt == BIT_LAST) begin
                        tail <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                        sh      <= sh_nxt;
                        sdo     <= next_bit;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/msi001_spi_sequencer.sv
// MSI001 SPI sequencer: table of DEPTH words sent as separate frames on start, done pulse at end.
// Latency: first frame en falls 2 cycles after start; gap of GAP_CYC en-high cycles between frames.
// Backpressure: start and cfg_we are ignored while busy. SPI_LSB_FIRST_EN selects LSB-first frames.
module msi001_spi_sequencer
    import msi001_spi_sequencer_pkg::*;
#(
    parameter  int DATA_W  = 24,
    parameter  int DEPTH   = 8,
    parameter  int CLK_DIV = 4,
    parameter  int GAP_CYC = 8,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic              start,
    input  logic [AW:0]       seq_len,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     word_idx,
    output logic              spi_data_out,
    output logic              spi_clk_out,
    output logic              spi_en_out
);

    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    // Exit GAP one cycle early when more words follow: the load cycle is itself en-high.
    localparam logic [GW-1:0] GAP_NXT  = GW'((GAP_CYC >= 2) ? GAP_CYC - 2 : 0);

    logic [DATA_W-1:0] tbl [DEPTH];
    seq_state_t        state;
    logic [AW-1:0]     last_idx;
    logic [GW-1:0]     gap_cnt;
    logic              more;
    logic              tx_load;
    logic              tx_clr;
    logic              tx_busy;
    logic              tx_tail;
    logic              tx_last;

    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            tbl[cfg_addr] <= cfg_wdata;
        end
    end

    assign more    = (word_idx != last_idx);
    assign tx_load = (state == ST_SHIFT) && !tx_busy;
    assign tx_clr  = (state == ST_FIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            word_idx <= '0;
            last_idx <= '0;
            gap_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (seq_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= ST_SHIFT;
                            busy     <= 1'b1;
                            word_idx <= '0;
                            last_idx <= AW'(clamp_len(32'(seq_len), DEPTH) - 1);
                        end
                    end
                end
                ST_SHIFT, ST_TAIL: begin
                    if (tx_last) begin
                        gap_cnt <= '0;
                        if (more && GAP_CYC == 1) begin
                            state    <= ST_SHIFT;
                            word_idx <= word_idx + AW'(1);
                        end else begin
                            state <= ST_GAP;
                        end
                    end else if (tx_tail) begin
                        state <= ST_TAIL;
                    end
                end
                ST_GAP: begin
                    if (more && gap_cnt == GAP_NXT) begin
                        state    <= ST_SHIFT;
                        word_idx <= word_idx + AW'(1);
                    end else if (!more && gap_cnt == GAP_LAST) begin
                        state    <= ST_FIN;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        word_idx <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    msi001_spi_word_tx #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_word_tx (
        .clk  (clk),
        .rst  (rst),
        .load (tx_load),
        .clr  (tx_clr),
        .word (tbl[word_idx]),
        .busy (tx_busy),
        .tail (tx_tail),
        .last (tx_last),
        .sdo  (spi_data_out),
        .sclk (spi_clk_out),
        .sen  (spi_en_out)
    );

endmodule

// File: tb/tb_msi001_spi_sequencer.sv
// Bench for msi001_spi_sequencer: a pin-level monitor decodes frames and a table model predicts them.
module tb_msi001_spi_sequencer;

    localparam int DATA_W  = 24;
    localparam int DEPTH   = 8;
    localparam int CLK_DIV = 2;
    localparam int GAP_CYC = 4;
    localparam int EN_LOW  = (2 * DATA_W + 1) * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [23:0] cfg_wdata;
    logic        start;
    logic [3:0]  seq_len;
    logic        busy;
    logic        done;
    logic [2:0]  word_idx;
    logic        spi_data_out;
    logic        spi_clk_out;
    logic        spi_en_out;

    msi001_spi_sequencer #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .CLK_DIV (CLK_DIV),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .start        (start),
        .seq_len      (seq_len),
        .busy         (busy),
        .done         (done),
        .word_idx     (word_idx),
        .spi_data_out (spi_data_out),
        .spi_clk_out  (spi_clk_out),
        .spi_en_out   (spi_en_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [23:0] tbl_m [DEPTH];

    // Pin-level monitor observations
    logic [23:0] frames [$];
    int          lows   [$];
    int          nbq    [$];
    int          gaps   [$];
    int          dgaps  [$];
    logic [2:0]  idxq   [$];
    logic        fbq    [$];
    int          busy_cyc   = 0;
    int          enlow_cyc  = 0;
    int          sclkhi_cyc = 0;
    int          done_cnt   = 0;
    int          low_run    = 0;
    int          gap_run    = 0;
    int          nbits      = 0;
    logic [23:0] cur        = '0;
    logic        in_seq     = 1'b0;
    logic        prev_en    = 1'b1;
    logic        prev_sclk  = 1'b0;

    always @(negedge clk) begin
        if (busy) busy_cyc <= busy_cyc + 1;
        if (!spi_en_out) enlow_cyc <= enlow_cyc + 1;
        if (spi_clk_out) sclkhi_cyc <= sclkhi_cyc + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            dgaps.push_back(gap_run);
        end
        if (!spi_en_out) begin
            if (prev_en) begin
                idxq.push_back(word_idx);
                if (in_seq) gaps.push_back(gap_run);
                low_run <= 1;
                nbits   <= 0;
                cur     <= '0;
            end else begin
                low_run <= low_run + 1;
                if (spi_clk_out && !prev_sclk) begin
                    if (nbits == 0) fbq.push_back(spi_data_out);
                    cur   <= {cur[22:0], spi_data_out};
                    nbits <= nbits + 1;
                end
            end
        end else begin
            if (!prev_en) begin
                frames.push_back(cur);
                lows.push_back(low_run);
                nbq.push_back(nbits);
                gap_run <= 1;
                in_seq  <= 1'b1;
            end else begin
                gap_run <= gap_run + 1;
            end
        end
        if (done || rst) in_seq <= 1'b0;
        prev_en   <= spi_en_out;
        prev_sclk <= spi_clk_out;
    end

    // Reference: what the pins must carry for a table word, given the compiled bit order.
    function automatic logic [23:0] exp_frame(input logic [23:0] w);
        logic [23:0] r;
`ifdef SPI_LSB_FIRST_EN
        for (int b = 0; b < 24; b++) r[b] = w[23-b];
`else
        r = w;
`endif
        return r;
    endfunction

    function automatic logic exp_first(input logic [23:0] w);
`ifdef SPI_LSB_FIRST_EN
        return w[0];
`else
        return w[23];
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] a, input logic [23:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tbl_m[a] = d;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    int fr0, gp0, dg0, dn0;

    task automatic launch(input logic [3:0] len, input logic we, input logic [2:0] a,
                          input logic [23:0] d);
        fr0 = frames.size(); gp0 = gaps.size(); dg0 = dgaps.size(); dn0 = done_cnt;
        cfg_we = we; cfg_addr = a; cfg_wdata = d;
        if (we) tbl_m[a] = d;
        start = 1'b1; seq_len = len;
        cyc(1);
        start = 1'b0; cfg_we = 1'b0;
        chk("launch_busy", busy, len != 0);
    endtask

    task automatic finish_seq(input int len, input string tag);
        int n;
        n = (len > DEPTH) ? DEPTH : len;
        for (int k = 0; k < 4000 && done_cnt == dn0; k++) @(posedge clk);
        cyc(2);
        chk({tag, "_done_cnt"}, done_cnt - dn0, 1);
        chk({tag, "_nframes"}, frames.size() - fr0, n);
        for (int i = 0; i < n; i++) begin
            if (fr0 + i < frames.size()) begin
                chk($sformatf("%s_data%0d", tag, i), frames[fr0+i], exp_frame(tbl_m[i]));
                chk($sformatf("%s_enlow%0d", tag, i), lows[fr0+i], EN_LOW);
                chk($sformatf("%s_nbits%0d", tag, i), nbq[fr0+i], DATA_W);
                chk($sformatf("%s_idx%0d", tag, i), idxq[fr0+i], i);
                chk($sformatf("%s_first%0d", tag, i), fbq[fr0+i], exp_first(tbl_m[i]));
            end
        end
        for (int i = 0; i + 1 < n; i++) begin
            if (gp0 + i < gaps.size())
                chk($sformatf("%s_gap%0d", tag, i), gaps[gp0+i], GAP_CYC);
        end
        chk({tag, "_ngaps"}, gaps.size() - gp0, n - 1);
        if (dg0 < dgaps.size()) chk({tag, "_done_gap"}, dgaps[dg0], GAP_CYC);
        chk({tag, "_idx_idle"}, word_idx, 0);
        chk({tag, "_busy_idle"}, busy, 0);
        chk({tag, "_en_idle"}, spi_en_out, 1);
        chk({tag, "_sdo_idle"}, spi_data_out, 0);
    endtask

    initial begin
        int b0, e0, s0, d0, len;
        logic [23:0] w;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0; seq_len = '0;
        cyc(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", word_idx, 0);
        chk("rst_sdo", spi_data_out, 0);
        chk("rst_sclk", spi_clk_out, 0);
        chk("rst_en", spi_en_out, 1);
        rst = 1'b0;
        cyc(2);

        // Default MSI001 frames
        write(3'd0, 24'hEBAEAB);
        write(3'd1, 24'h09AFAB);
        launch(4'd2, 1'b0, 3'd0, 24'h0);
        finish_seq(2, "t1");

        // Zero-length request: done only
        b0 = busy_cyc; e0 = enlow_cyc; s0 = sclkhi_cyc; d0 = done_cnt;
        start = 1'b1; seq_len = 4'd0;
        cyc(1);
        start = 1'b0;
        chk("t2_done_next", done, 1);
        cyc(1);
        chk("t2_done_pulse", done, 0);
        cyc(6);
        chk("t2_busy_quiet", busy_cyc - b0, 0);
        chk("t2_en_quiet", enlow_cyc - e0, 0);
        chk("t2_sclk_quiet", sclkhi_cyc - s0, 0);
        chk("t2_done_once", done_cnt - d0, 1);

        // Full table, distinct randomized entries
        for (int i = 0; i < DEPTH; i++) write(3'(i), {5'(i), 19'($urandom)});
        launch(4'd8, 1'b0, 3'd0, 24'h0);
        finish_seq(8, "t3");

        // Write and start attempts while busy are dropped
        launch(4'd2, 1'b0, 3'd0, 24'h0);
        cyc(30);
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = ~tbl_m[1];
        start = 1'b1; seq_len = 4'd1;
        cyc(1);
        cfg_we = 1'b0; start = 1'b0;
        finish_seq(2, "t4");

        // Asynchronous reset in the middle of bit 10
        launch(4'd3, 1'b0, 3'd0, 24'h0);
        for (int k = 0; k < 50 && spi_en_out; k++) cyc(1);
        chk("t5_en_fell", spi_en_out, 0);
        cyc(42);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_en", spi_en_out, 1);
        chk("t5_sclk", spi_clk_out, 0);
        chk("t5_sdo", spi_data_out, 0);
        chk("t5_idx", word_idx, 0);
        chk("t5_done", done, 0);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        launch(4'd3, 1'b0, 3'd0, 24'h0);
        finish_seq(3, "t5b");

        // Single word 000001: first bit shows the compiled order
        write(3'd0, 24'h000001);
        launch(4'd1, 1'b0, 3'd0, 24'h0);
        finish_seq(1, "t6");

        // Randomized lengths (including clamped ones) with a simultaneous write on start
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, 15);
            w = 24'($urandom);
            launch(4'(len), 1'b1, 3'($urandom_range(0, 7)), w);
            finish_seq(len, $sformatf("rnd%0d", r));
            cyc($urandom_range(1, 5));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
